oven_control: RTL and testbench
===============================

# oven_control

Main sequencer of the microwave. Turns keypad digits and the start, stop and door inputs into the load, clear and count-enable controls of the countdown timer. Drives the magnetron enable and the end-of-cook beeper. Sits between the keypad/door front end and the timer instance; all timer control ports are driven only by this block.

## Interface
Parameters:
- TICK_DIV, 100: clk cycles per timer decrement; range 2..65535.
- BEEP_CYCLES, 50: length of the end-of-cook beep in clk cycles; range 1..65535.
- DIGIT_MAX, 3: maximum digits accepted per entry.

Ports:
- clk  in  1: system clock; rising-edge active.
- clrn  in  1: asynchronous, active-low reset.
- key_data  in  4: keypad code; only codes 0..9 are digits.
- key_strobe  in  1: key valid; acted on at its rising edge.
- startn  in  1: start button, active low; acted on at its falling edge.
- stopn  in  1: stop/cancel button, active low; acted on at its falling edge.
- door_closed  in  1: 1 = door latched (level).
- timer_zero  in  1: timer reports 0:00.
- timer_data  out  4: digit presented to the timer.
- timer_loadn  out  1: active-low, one-cycle digit load to the timer.
- timer_clrn  out  1: active-low, one-cycle timer clear.
- timer_en  out  1: one-cycle decrement pulse to the timer.
- mag_on  out  1: magnetron enable.
- beep  out  1: buzzer.
- busy  out  1: high in any state other than IDLE.

## Operation
- Inputs are synchronous to clk. Edge detection uses a one-cycle history register per input. The history resets to the inactive level: key_strobe 0, startn 1, stopn 1.
- All outputs are registered.
- States: IDLE, ENTRY, COOKING, PAUSED, DONE. With QUICK_START_EN there are also QS_LOAD1 and QS_LOAD0.
- IDLE:
  - A digit edge loads the timer and goes to ENTRY.
  - Codes 10..15 are ignored in every state.
- ENTRY:
  - Digits are loaded while digit_cnt < DIGIT_MAX; further digits are ignored.
  - Start is honoured only when door_closed=1 and timer_zero=0; it goes to COOKING.
  - Stop clears the timer and goes to IDLE.
- COOKING:
  - mag_on=1; the prescaler emits timer_en.
  - Stop goes to PAUSED. Door open goes to PAUSED. timer_zero goes to DONE.
  - Key presses are ignored.
- PAUSED:
  - mag_on=0; no ticks are emitted and the prescaler holds.
  - Start with the door closed returns to COOKING and the prescaler restarts from 0.
  - A second stop clears the timer and goes to IDLE.
- DONE:
  - beep=1 for BEEP_CYCLES cycles, then IDLE.
  - Stop or door open ends the beep early and goes to IDLE.
  - The timer is not cleared in DONE.
- Priority when events coincide in one cycle: stop > door open > timer_zero > start > key.
- A digit load is a one-cycle pulse: timer_loadn=0 with timer_data=key_data. digit_cnt increments; it clears on entry to IDLE.

## Timing
- Reset values: timer_data=0, timer_loadn=1, timer_clrn=1, timer_en=0, mag_on=0, beep=0, busy=0. State is IDLE; prescaler, beep counter and digit_cnt are 0.
- Latency: an input edge sampled at clk edge N changes the state and outputs at edge N. They are visible during cycle N..N+1.
- Pulse widths: timer_loadn, timer_clrn and timer_en pulses are exactly one cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in COOKING.
  - timer_en=1 in the cycle in which the count equals TICK_DIV-1; the count then wraps to 0.
  - First tick comes TICK_DIV cycles after entering COOKING.
- timer_zero sampled high in COOKING forces timer_en=0 and mag_on=0 from the same edge; no extra decrement past 0:00.
- Reset asserted mid-cook drops mag_on and beep asynchronously. The timer is not cleared by this block; it shares clrn.

## Configuration
- Macro: OVEN_QUICK_START_EN.
- With the macro defined: start in IDLE with door_closed=1 runs QS_LOAD1, then QS_LOAD0, then COOKING. QS_LOAD1 loads digit 3 and QS_LOAD0 loads digit 0, giving 30 s; one cycle each.
- With the macro defined, stop or door open during QS_LOAD1 or QS_LOAD0 clears the timer and returns to IDLE.
- Without the macro: start in IDLE is ignored and the QS states are not compiled.

## Structure
- Shared package oven_pkg holds:
  - the state encoding;
  - KEY_DIGIT_MAX=9;
  - the quick-start digits QS_DIGIT1=3 and QS_DIGIT0=0.
- Sub-module tick_prescaler holds the modulo-TICK_DIV counter. Ports: clk, clrn, run, restart, tick.
- The FSM, edge detectors and beep counter live in oven_control.

## Test plan
Bench settings: TICK_DIV=4, BEEP_CYCLES=3, behavioural timer model.
- Digit entry: keys 1, 2, 9 then a fourth key 5 -> three timer_loadn pulses with data 1, 2, 9; key 5 is ignored; state ENTRY; busy=1.
- Cook to completion: entry 0, 2 then start with the door closed -> mag_on=1; timer_en on every 4th cycle; two ticks, then timer_zero -> mag_on=0 on the same edge; beep=1 for 3 cycles; then IDLE.
- Door interlock: start with door_closed=0 in ENTRY -> stays ENTRY with mag_on=0. Door opened mid-cook -> PAUSED with no timer_en. Door closed and start -> first tick 4 cycles later.
- Simultaneous stop and timer_zero in COOKING -> PAUSED, beep stays 0. A second stop -> one timer_clrn pulse, then IDLE.
- Reset mid-cook: clrn low asynchronously -> mag_on=0 and busy=0 immediately; after release, all outputs hold their reset values.
- Quick start with OVEN_QUICK_START_EN: start in IDLE -> loads 3 then 0 on consecutive cycles, then COOKING. Without the macro the same stimulus leaves the block in IDLE.

Source files
------------

// File: rtl/oven_pkg.sv
// oven_pkg: state encoding and keypad / quick-start constants shared by oven_control.
// The QS_LOAD states exist only when OVEN_QUICK_START_EN is defined.
package oven_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTRY    = 3'd1,
        COOKING  = 3'd2,
        PAUSED   = 3'd3,
        DONE     = 3'd4
`ifdef OVEN_QUICK_START_EN
        ,
        QS_LOAD1 = 3'd5,
        QS_LOAD0 = 3'd6
`endif
    } oven_state_e;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] QS_DIGIT1     = 4'd3;
    localparam logic [3:0] QS_DIGIT0     = 4'd0;

    function automatic logic isDigit(input logic [3:0] code);
        return code <= KEY_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: modulo-TICK_DIV counter that emits one tick per TICK_DIV running cycles.
// Holds its count while run is low; restart forces the count back to zero.
module tick_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic clrn,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign tick = run && (cnt_q == TICK_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/oven_control.sv
// oven_control: microwave main sequencer driving the countdown timer, magnetron and beeper.
// Define OVEN_QUICK_START_EN to make start in IDLE load a 30 s cook and run it.
module oven_control
    import oven_pkg::*;
#(
    parameter int TICK_DIV    = 100,
    parameter int BEEP_CYCLES = 50,
    parameter int DIGIT_MAX   = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [3:0] key_data,
    input  logic       key_strobe,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] timer_data,
    output logic       timer_loadn,
    output logic       timer_clrn,
    output logic       timer_en,
    output logic       mag_on,
    output logic       beep,
    output logic       busy
);

    localparam int                 DIGIT_W     = $clog2(DIGIT_MAX + 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LIMIT = DIGIT_W'(DIGIT_MAX);
    localparam logic [15:0]        BEEP_LAST   = 16'(BEEP_CYCLES - 1);

    oven_state_e        state_q, state_d;
    logic               keyHist_q, startHist_q, stopHist_q;
    logic [DIGIT_W-1:0] digitCnt_q, digitCnt_d;
    logic [15:0]        beepCnt_q, beepCnt_d;
    logic [3:0]         timerData_q, timerData_d;
    logic               timerLoadn_q, timerLoadn_d;
    logic               timerClrn_q, timerClrn_d;
    logic               timerEn_q, timerEn_d;
    logic               magOn_q, magOn_d;
    logic               beep_q, beep_d;
    logic               busy_q, busy_d;

    logic keyDigit, startFall, stopFall, doorOpen;
    logic prescRun, prescRestart, prescTick;

    assign keyDigit  = key_strobe && !keyHist_q && isDigit(key_data);
    assign startFall = !startn && startHist_q;
    assign stopFall  = !stopn && stopHist_q;
    assign doorOpen  = !door_closed;

    // The prescaler only advances while cooking continues; any entry into COOKING restarts it.
    assign prescRun     = (state_q == COOKING) && (state_d == COOKING);
    assign prescRestart = (state_q != COOKING) && (state_d == COOKING);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .clrn   (clrn),
        .run    (prescRun),
        .restart(prescRestart),
        .tick   (prescTick)
    );

    always_comb begin
        state_d      = state_q;
        digitCnt_d   = digitCnt_q;
        beepCnt_d    = beepCnt_q;
        timerData_d  = timerData_q;
        timerLoadn_d = 1'b1;
        timerClrn_d  = 1'b1;
        case (state_q)
            IDLE: begin
`ifdef OVEN_QUICK_START_EN
                if (startFall && door_closed) begin
                    state_d      = QS_LOAD1;
                    timerLoadn_d = 1'b0;
                    timerData_d  = QS_DIGIT1;
                end else
`endif
                if (keyDigit) begin
                    state_d      = ENTRY;
                    timerLoadn_d = 1'b0;
                    timerData_d  = key_data;
                    digitCnt_d   = digitCnt_q + DIGIT_W'(1);
                end
            end
            ENTRY: begin
                if (stopFall) begin
                    state_d     = IDLE;
                    timerClrn_d = 1'b0;
                end else if (startFall && door_closed && !timer_zero) begin
                    state_d = COOKING;
                end else if (keyDigit && (digitCnt_q < DIGIT_LIMIT)) begin
                    timerLoadn_d = 1'b0;
                    timerData_d  = key_data;
                    digitCnt_d   = digitCnt_q + DIGIT_W'(1);
                end
            end
            COOKING: begin
                if (stopFall || doorOpen) begin
                    state_d = PAUSED;
                end else if (timer_zero) begin
                    state_d   = DONE;
                    beepCnt_d = '0;
                end
            end
            PAUSED: begin
                if (stopFall) begin
                    state_d     = IDLE;
                    timerClrn_d = 1'b0;
                end else if (startFall && door_closed) begin
                    state_d = COOKING;
                end
            end
            DONE: begin
                if (stopFall || doorOpen || (beepCnt_q == BEEP_LAST)) begin
                    state_d = IDLE;
                end else begin
                    beepCnt_d = beepCnt_q + 16'd1;
                end
            end
`ifdef OVEN_QUICK_START_EN
            QS_LOAD1: begin
                if (stopFall || doorOpen) begin
                    state_d     = IDLE;
                    timerClrn_d = 1'b0;
                end else begin
                    state_d      = QS_LOAD0;
                    timerLoadn_d = 1'b0;
                    timerData_d  = QS_DIGIT0;
                end
            end
            QS_LOAD0: begin
                if (stopFall || doorOpen) begin
                    state_d     = IDLE;
                    timerClrn_d = 1'b0;
                end else begin
                    state_d = COOKING;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) begin
            digitCnt_d = '0;
        end
    end

    // Outputs decode the next state so they change on the same edge as the state.
    assign timerEn_d = prescTick;
    assign magOn_d   = (state_d == COOKING);
    assign beep_d    = (state_d == DONE);
    assign busy_d    = (state_d != IDLE);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            keyHist_q    <= 1'b0;
            startHist_q  <= 1'b1;
            stopHist_q   <= 1'b1;
            digitCnt_q   <= '0;
            beepCnt_q    <= '0;
            timerData_q  <= 4'd0;
            timerLoadn_q <= 1'b1;
            timerClrn_q  <= 1'b1;
            timerEn_q    <= 1'b0;
            magOn_q      <= 1'b0;
            beep_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            keyHist_q    <= key_strobe;
            startHist_q  <= startn;
            stopHist_q   <= stopn;
            digitCnt_q   <= digitCnt_d;
            beepCnt_q    <= beepCnt_d;
            timerData_q  <= timerData_d;
            timerLoadn_q <= timerLoadn_d;
            timerClrn_q  <= timerClrn_d;
            timerEn_q    <= timerEn_d;
            magOn_q      <= magOn_d;
            beep_q       <= beep_d;
            busy_q       <= busy_d;
        end
    end

    assign timer_data  = timerData_q;
    assign timer_loadn = timerLoadn_q;
    assign timer_clrn  = timerClrn_q;
    assign timer_en    = timerEn_q;
    assign mag_on      = magOn_q;
    assign beep        = beep_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_oven_control.sv
// tb_oven_control: randomized scoreboard bench for oven_control with a behavioural countdown timer.
// Expected timer pulses are queued by the stimulus and popped by an independent monitor.
module tb_oven_control;

    localparam int TB_TICK   = 4;
    localparam int TB_BEEP   = 3;
    localparam int TB_DIGITS = 3;

    localparam int EV_LOAD = 0;
    localparam int EV_CLR  = 1;
    localparam int EV_TICK = 2;

    localparam int STIM_KEY   = 0;
    localparam int STIM_START = 1;
    localparam int STIM_STOP  = 2;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } ev_t;

    logic       clk         = 1'b0;
    logic       clrn        = 1'b0;
    logic [3:0] key_data    = 4'd0;
    logic       key_strobe  = 1'b0;
    logic       startn      = 1'b1;
    logic       stopn       = 1'b1;
    logic       door_closed = 1'b1;
    logic       timer_zero;
    logic [3:0] timer_data;
    logic       timer_loadn, timer_clrn, timer_en, mag_on, beep, busy;

    int  cyc     = 0;
    int  checks  = 0;
    int  errors  = 0;
    int  tVal    = 0;
    int  entered = 0;
    int  secs    = 0;
    ev_t expQ[$];

    oven_control #(
        .TICK_DIV   (TB_TICK),
        .BEEP_CYCLES(TB_BEEP),
        .DIGIT_MAX  (TB_DIGITS)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .key_data   (key_data),
        .key_strobe (key_strobe),
        .startn     (startn),
        .stopn      (stopn),
        .door_closed(door_closed),
        .timer_zero (timer_zero),
        .timer_data (timer_data),
        .timer_loadn(timer_loadn),
        .timer_clrn (timer_clrn),
        .timer_en   (timer_en),
        .mag_on     (mag_on),
        .beep       (beep),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural decimal countdown timer: loads shift a digit in, ticks count down to zero.
    always @(posedge clk or negedge clrn) begin
        if (!clrn)             tVal <= 0;
        else if (!timer_clrn)  tVal <= 0;
        else if (!timer_loadn) tVal <= (tVal * 10 + int'(timer_data)) % 1000;
        else if (timer_en && tVal > 0) tVal <= tVal - 1;
    end
    assign timer_zero = (tVal == 0);

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expectEvent(input int kind, input int data, input int c);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = c;
        expQ.push_back(e);
    endtask

    task automatic scoreEvent(input int kind, input int data);
        ev_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_pulse: got kind %0d data %0d at cycle %0d, expected none", kind, data, cyc);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || e.data != data || e.cyc != cyc) begin
                errors++;
                $display("[TB] FAIL pulse: got kind %0d data %0d cycle %0d, expected kind %0d data %0d cycle %0d",
                         kind, data, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    // Monitor: every timer-control pulse the DUT presents is matched against the queue head.
    always @(negedge clk) begin
        if (clrn) begin
            if (!timer_loadn) scoreEvent(EV_LOAD, int'(timer_data));
            if (!timer_clrn)  scoreEvent(EV_CLR, 0);
            if (timer_en)     scoreEvent(EV_TICK, 0);
        end
    end

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) tick1();
    endtask

    task automatic applyStimulus(input int kind, input logic [3:0] code, output int edgeCyc);
        case (kind)
            STIM_KEY:   begin key_data = code; key_strobe = 1'b1; end
            STIM_START: startn = 1'b0;
            default:    stopn = 1'b0;
        endcase
        tick1();
        edgeCyc    = cyc;
        key_strobe = 1'b0;
        startn     = 1'b1;
        stopn      = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic expMag, input logic expBeep, input logic expBusy);
        compare({name, ".mag_on"}, 32'(mag_on), 32'(expMag));
        compare({name, ".beep"}, 32'(beep), 32'(expBeep));
        compare({name, ".busy"}, 32'(busy), 32'(expBusy));
    endtask

    task automatic checkAt(input int c, input string name, input logic expMag, input logic expBeep, input logic expBusy);
        waitUntil(c);
        @(negedge clk);
        checkOutput(name, expMag, expBeep, expBusy);
    endtask

    task automatic checkReset(input string name);
        compare({name, ".timer_data"}, 32'(timer_data), 32'd0);
        compare({name, ".timer_loadn"}, 32'(timer_loadn), 32'd1);
        compare({name, ".timer_clrn"}, 32'(timer_clrn), 32'd1);
        compare({name, ".timer_en"}, 32'(timer_en), 32'd0);
        checkOutput(name, 1'b0, 1'b0, 1'b0);
    endtask

    // Reference entry rule: digits 0..9 are accepted until TB_DIGITS have been taken.
    task automatic pressKey(input logic [3:0] code);
        int e;
        applyStimulus(STIM_KEY, code, e);
        if (int'(code) <= 9 && entered < TB_DIGITS) begin
            expectEvent(EV_LOAD, int'(code), e);
            entered++;
            secs = secs * 10 + int'(code);
        end
        repeat ($urandom_range(1, 3)) tick1();
    endtask

    task automatic clearModel();
        entered = 0;
        secs    = 0;
    endtask

    initial begin
        int e, e2, s, s2, p, n, r, gap;
        logic [3:0] d[4];

        repeat (3) @(posedge clk);
        #1 clrn = 1'b1;
        @(negedge clk);
        checkReset("reset");

        // Digit entry with the DIGIT_MAX limit and non-digit codes.
        pressKey(4'(10 + $urandom_range(0, 5)));
        @(negedge clk);
        checkOutput("idle_nondigit", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) d[i] = 4'($urandom_range(0, 9));
        pressKey(d[0]);
        pressKey(4'(10 + $urandom_range(0, 5)));
        pressKey(d[1]);
        pressKey(d[2]);
        pressKey(d[3]);
        @(negedge clk);
        checkOutput("entry_full", 1'b0, 1'b0, 1'b1);
        applyStimulus(STIM_STOP, 4'd0, e);
        expectEvent(EV_CLR, 0, e);
        checkAt(e, "entry_stop", 1'b0, 1'b0, 1'b0);
        clearModel();

        // Cook to completion.
        tick1();
        n = $urandom_range(1, 3);
        pressKey(4'd0);
        pressKey(4'(n));
        applyStimulus(STIM_START, 4'd0, e);
        for (int m = 1; m <= secs; m++) expectEvent(EV_TICK, 0, e + TB_TICK * m);
        checkAt(e, "cook_start", 1'b1, 1'b0, 1'b1);
        checkAt(e + TB_TICK * n + 1, "cook_last", 1'b1, 1'b0, 1'b1);
        checkAt(e + TB_TICK * n + 2, "cook_done", 1'b0, 1'b1, 1'b1);
        checkAt(e + TB_TICK * n + 1 + TB_BEEP, "beep_last", 1'b0, 1'b1, 1'b1);
        checkAt(e + TB_TICK * n + 2 + TB_BEEP, "cook_idle", 1'b0, 1'b0, 1'b0);
        clearModel();

        // Door interlock: refused start, pause on door open, resume with restarted prescaler.
        tick1();
        pressKey(4'd0);
        pressKey(4'd3);
        door_closed = 1'b0;
        tick1();
        applyStimulus(STIM_START, 4'd0, e);
        checkAt(e + 1, "interlock_refuse", 1'b0, 1'b0, 1'b1);
        tick1();
        door_closed = 1'b1;
        applyStimulus(STIM_START, 4'd0, e);
        expectEvent(EV_TICK, 0, e + TB_TICK);
        checkAt(e, "interlock_cook", 1'b1, 1'b0, 1'b1);
        waitUntil(e + TB_TICK + 1);
        door_closed = 1'b0;
        tick1();
        p = cyc;
        checkAt(p, "door_pause", 1'b0, 1'b0, 1'b1);
        gap = $urandom_range(3, 8);
        checkAt(p + gap, "pause_hold", 1'b0, 1'b0, 1'b1);
        tick1();
        door_closed = 1'b1;
        applyStimulus(STIM_START, 4'd0, e2);
        for (int m = 1; m <= secs - 1; m++) expectEvent(EV_TICK, 0, e2 + TB_TICK * m);
        checkAt(e2, "resume", 1'b1, 1'b0, 1'b1);
        checkAt(e2 + TB_TICK * (secs - 1) + 2, "resume_done", 1'b0, 1'b1, 1'b1);
        checkAt(e2 + TB_TICK * (secs - 1) + 2 + TB_BEEP, "resume_idle", 1'b0, 1'b0, 1'b0);
        clearModel();

        // Stop coinciding with timer_zero wins; second stop clears.
        tick1();
        pressKey(4'd0);
        pressKey(4'd1);
        applyStimulus(STIM_START, 4'd0, e);
        expectEvent(EV_TICK, 0, e + TB_TICK);
        checkAt(e, "zs_cook", 1'b1, 1'b0, 1'b1);
        waitUntil(e + TB_TICK + 1);
        applyStimulus(STIM_STOP, 4'd0, s);
        checkAt(s, "zs_paused", 1'b0, 1'b0, 1'b1);
        checkAt(s + 1, "zs_no_beep", 1'b0, 1'b0, 1'b1);
        tick1();
        applyStimulus(STIM_STOP, 4'd0, s2);
        expectEvent(EV_CLR, 0, s2);
        checkAt(s2, "zs_idle", 1'b0, 1'b0, 1'b0);
        clearModel();

        // Asynchronous reset mid-cook.
        tick1();
        pressKey(4'd0);
        pressKey(4'd9);
        applyStimulus(STIM_START, 4'd0, e);
        for (int m = 1; m <= secs; m++) expectEvent(EV_TICK, 0, e + TB_TICK * m);
        r = $urandom_range(1, 12);
        waitUntil(e + r);
        #1;
        expQ.delete();
        clrn = 1'b0;
        #1;
        compare("async_reset.mag_on", 32'(mag_on), 32'd0);
        compare("async_reset.busy", 32'(busy), 32'd0);
        repeat (2) tick1();
        clrn = 1'b1;
        clearModel();
        @(negedge clk);
        checkReset("post_reset");
        repeat (3) tick1();
        @(negedge clk);
        checkReset("post_reset_hold");

        // Quick start from IDLE.
        tick1();
        door_closed = 1'b1;
        applyStimulus(STIM_START, 4'd0, e);
`ifdef OVEN_QUICK_START_EN
        expectEvent(EV_LOAD, 3, e);
        expectEvent(EV_LOAD, 0, e + 1);
        checkAt(e + 2, "qs_cook", 1'b1, 1'b0, 1'b1);
        applyStimulus(STIM_STOP, 4'd0, s);
        checkAt(s, "qs_paused", 1'b0, 1'b0, 1'b1);
        tick1();
        applyStimulus(STIM_STOP, 4'd0, s2);
        expectEvent(EV_CLR, 0, s2);
        checkAt(s2, "qs_idle", 1'b0, 1'b0, 1'b0);
`else
        checkAt(e, "qs_ignored", 1'b0, 1'b0, 1'b0);
        checkAt(e + 2, "qs_ignored_hold", 1'b0, 1'b0, 1'b0);
`endif

        repeat (4) tick1();
        compare("pulse_queue_drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
